uart_rx: RTL and testbench
==========================

# uart_rx

Serial UART receiver with 8× oversampling. It samples a single asynchronous-line input `rx_in` at 8 clock ticks per bit and deframes one start bit, 8 data bits and an optional parity bit (odd or even). It then checks the stop bit and presents the byte on `p_data` with a `data_valid` flag. It sits between the board-level RX pin (already synchronized upstream) and the byte-level consumer.

## Interface
- `PRESCALE`, 8: clock ticks per bit; fixed at 8 for this revision.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rx_in` in 1: serial line, idle high; assumed already synchronous to `clk`.
- `par_en` in 1: 1 means a parity bit follows the data bits.
- `par_type` in 1: 1 selects odd parity, 0 selects even; ignored when `par_en`=0.
- `data_valid` out 1: high when the last frame completed with no error; held until the next start is detected.
- `p_data` out 8: last error-free received byte.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Internal counters:
  - `edge_cnt` 0..7 counts ticks within the current bit.
  - `bit_cnt` 0..7 counts data bits.
- IDLE: the first cycle with `rx_in`=0 is tick 0 of the start bit.
  - Go to START.
  - Clear `par_err`, `stp_err` and `strt_glitch`.
  - Drop `data_valid`.
- Sampling: each bit's value is the majority of `rx_in` at ticks 3, 4 and 5, resolved at tick 5.
  - Each state advances after tick 7.
- START: if the sampled value is 1, set `strt_glitch` and return to IDLE at tick 7. Otherwise go to DATA.
- DATA: 8 bits are received MSB first. The first data bit lands in `p_data[7]` and the last in `p_data[0]`.
  - Bits shift into an internal register.
  - After the 8th bit, go to PARITY if `par_en`=1, else STOP.
- PARITY: expected bit is XOR of the 8 data bits, inverted when `par_type`=1 (odd).
  - A mismatch sets `par_err`.
  - Always proceeds to STOP.
- STOP: a sampled value of 0 sets `stp_err`.
  - At tick 6, if `par_err`=0 and `stp_err`=0, load `p_data` from the shift register and set `data_valid`=1.
  - Otherwise `p_data` is unchanged and `data_valid` stays 0.
  - After tick 7, return to IDLE.
- `par_err`, `stp_err` and `strt_glitch` are internal registers with exactly these names; the bench probes them hierarchically. Each holds its value until the next start detection or reset.
- `par_en` and `par_type` are sampled continuously. They must be stable from start bit to stop bit; behaviour if they change mid-frame is undefined.
- A line held low after a frame is treated as a new start bit once the FSM is back in IDLE.

## Timing
- Reset: state IDLE, counters 0, `p_data`=8'h00, `data_valid`=0, all error flags 0.
- Reset mid-frame aborts the frame with no `data_valid` and leaves `p_data`=0.
- Frame length:
  - 10 bits × 8 = 80 cycles without parity.
  - 11 bits × 8 = 88 cycles with parity.
- `data_valid` rises at tick 6 of the stop bit: 6 cycles after the stop bit begins, or 86 cycles after start detection with parity.
- `data_valid` stays high through the end of the stop bit, through idle, and until the cycle after the next start detection.
- Error flags update at tick 5 of the relevant bit.

## Test plan
- Odd parity (`par_en`=1, `par_type`=1):
  - Stimulus: start 0, data 1,1,1,0,1,0,1,1, parity 1, stop 1, each held 8 cycles.
  - Required at the end of the stop bit: `p_data`=8'b11101011, `data_valid`=1, `par_err`=`stp_err`=`strt_glitch`=0.
- Even parity (`par_en`=1, `par_type`=0):
  - Stimulus: data 1,0,1,0,1,1,1,1, parity 0, stop 1.
  - Required 9 cycles after the stop bit begins: `p_data`=8'b10101111, `data_valid`=1.
- Parity error: the odd-parity frame above with parity bit 0.
  - Required: `par_err`=1, `data_valid`=0, `p_data` keeps its previous value.
- Stop error: any frame with stop bit 0.
  - Required: `stp_err`=1, `data_valid`=0.
  - The FSM returns to IDLE; a following good frame is received correctly.
- Start glitch: `rx_in` low for 2 cycles, then high.
  - Required: `strt_glitch`=1, FSM in IDLE by cycle 8, no `data_valid`.
- No parity (`par_en`=0):
  - Stimulus: data 0,1,0,1,0,1,0,1, then stop.
  - Required: `p_data`=8'h55 and `data_valid`=1 at tick 6 of the 10th bit.
  - Also assert `rst` mid-data and require all outputs to be 0 on the next cycle.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8x-oversampled UART receiver (start, 8 data MSB first, optional parity, stop)
// Ports: clk, rst (sync, active-high), rx_in (serial line, idle high),
//        par_en (parity bit present), par_type (1 odd, 0 even),
//        data_valid (last frame good, held until next start), p_data (last good byte)
module uart_rx #(
  parameter int PRESCALE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic       par_en,
  input  logic       par_type,
  output logic       data_valid,
  output logic [7:0] p_data
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
  localparam logic [2:0] LAST = 3'(PRESCALE - 1);
  state_e     state_q, state_d;
  logic [2:0] edge_cnt_q, edge_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [1:0] samp_q, samp_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] p_data_d;
  logic       data_valid_d;
  logic       par_err, par_err_d;
  logic       stp_err, stp_err_d;
  logic       strt_glitch, strt_glitch_d;
  logic       maj, last;
  // bit value: majority of ticks 3 and 4 (stored) and tick 5 (live)
  assign maj  = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_in) | (samp_q[1] & rx_in);
  assign last = edge_cnt_q == LAST;
  always_comb begin
    state_d       = state_q;
    edge_cnt_d    = edge_cnt_q + 3'd1;
    bit_cnt_d     = bit_cnt_q;
    samp_d        = samp_q;
    shift_d       = shift_q;
    p_data_d      = p_data;
    data_valid_d  = data_valid;
    par_err_d     = par_err;
    stp_err_d     = stp_err;
    strt_glitch_d = strt_glitch;
    if (edge_cnt_q == 3'd3) samp_d[0] = rx_in;
    if (edge_cnt_q == 3'd4) samp_d[1] = rx_in;
    case (state_q)
      IDLE: begin
        edge_cnt_d = 3'd0;
        if (!rx_in) begin
          // this cycle is tick 0 of the start bit
          state_d       = START;
          edge_cnt_d    = 3'd1;
          bit_cnt_d     = 3'd0;
          par_err_d     = 1'b0;
          stp_err_d     = 1'b0;
          strt_glitch_d = 1'b0;
          data_valid_d  = 1'b0;
        end
      end
      START: begin
        if (edge_cnt_q == 3'd5) strt_glitch_d = maj;
        if (last) state_d = strt_glitch ? IDLE : DATA;
      end
      DATA: begin
        if (edge_cnt_q == 3'd5) shift_d = {shift_q[6:0], maj};
        if (last) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = par_en ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (edge_cnt_q == 3'd5) par_err_d = maj != ((^shift_q) ^ par_type);
        if (last) state_d = STOP;
      end
      STOP: begin
        if (edge_cnt_q == 3'd5) stp_err_d = !maj;
        if (edge_cnt_q == 3'd6 && !par_err && !stp_err) begin
          p_data_d     = shift_q;
          data_valid_d = 1'b1;
        end
        if (last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      edge_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      samp_q      <= '0;
      shift_q     <= '0;
      p_data      <= '0;
      data_valid  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      strt_glitch <= 1'b0;
    end else begin
      state_q     <= state_d;
      edge_cnt_q  <= edge_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      samp_q      <= samp_d;
      shift_q     <= shift_d;
      p_data      <= p_data_d;
      data_valid  <= data_valid_d;
      par_err     <= par_err_d;
      stp_err     <= stp_err_d;
      strt_glitch <= strt_glitch_d;
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized frames against a frame-level reference model for uart_rx
module tb_uart_rx;
  logic       clk = 1'b0;
  logic       rst, rx_in, par_en, par_type;
  logic       data_valid;
  logic [7:0] p_data;
  int         errs = 0;
  int         checks = 0;
  logic [7:0] exp_pd = 8'h00;
  logic       exp_dv = 1'b0;
  always #5 clk = ~clk;
  uart_rx dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .par_en(par_en), .par_type(par_type),
    .data_valid(data_valid), .p_data(p_data)
  );
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick(logic v);
    rx_in = v;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick(1'b1);
  endtask
  task automatic send(logic [7:0] d, logic pen, logic pt, logic pb, logic sb, logic noisy);
    logic [10:0] bits;
    logic        perr, serr, ok;
    int          n, ft;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[7-i];
    bits[9]  = pen ? pb : sb;
    bits[10] = sb;
    n    = pen ? 11 : 10;
    perr = pen && (pb != ((^d) ^ pt));
    serr = !sb;
    ok   = !perr && !serr;
    par_en   = pen;
    par_type = pt;
    check("dv_hold", data_valid, exp_dv);
    for (int b = 0; b < n; b++) begin
      ft = -1;
      if (noisy && $urandom_range(1, 0) == 1) ft = (b == 0) ? $urandom_range(7, 1) : $urandom_range(7, 0);
      for (int t = 0; t < 8; t++) begin
        tick(t == ft ? ~bits[b] : bits[b]);
        if (b == 0 && t == 0) check("dv_drop", data_valid, 0);
        if (b == n - 1 && t == 5) check("dv_pre", data_valid, 0);
        if (b == n - 1 && t == 6) check("dv_rise", data_valid, ok);
      end
    end
    if (ok) exp_pd = d;
    exp_dv = ok;
    check("p_data", p_data, exp_pd);
    check("data_valid", data_valid, exp_dv);
    check("par_err", dut.par_err, perr);
    check("stp_err", dut.stp_err, serr);
    check("strt_glitch", dut.strt_glitch, 0);
    rx_in = 1'b1;
  endtask
  initial begin
    logic [7:0] d;
    logic       pen, pt, pb, sb;
    rst = 1'b1; rx_in = 1'b1; par_en = 1'b0; par_type = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_p_data", p_data, 8'h00);
    check("rst_dv", data_valid, 0);
    check("rst_perr", dut.par_err, 0);
    check("rst_serr", dut.stp_err, 0);
    check("rst_glitch", dut.strt_glitch, 0);
    idle(3);
    send(8'b11101011, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(2);
    send(8'b10101111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    check("even_hold", p_data, 8'b10101111);
    send(8'b11101011, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1);
    send(8'h3c, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'h96, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b0); tick(1'b0);
    idle(6);
    exp_dv = 1'b0;
    check("glitch_flag", dut.strt_glitch, 1);
    check("glitch_dv", data_valid, 0);
    check("glitch_pd", p_data, exp_pd);
    send(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    for (int i = 0; i < 28; i++) tick(i < 8 ? 1'b0 : i[0]);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rx_in = 1'b1;
    exp_pd = 8'h00;
    exp_dv = 1'b0;
    check("mid_rst_pd", p_data, 8'h00);
    check("mid_rst_dv", data_valid, 0);
    check("mid_rst_perr", dut.par_err, 0);
    check("mid_rst_serr", dut.stp_err, 0);
    idle(2);
    send(8'hc3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 40; k++) begin
      d   = 8'($urandom);
      pen = 1'($urandom);
      pt  = 1'($urandom);
      pb  = ($urandom_range(9, 0) < 8) ? ((^d) ^ pt) : ~((^d) ^ pt);
      sb  = $urandom_range(9, 0) < 8;
      send(d, pen, pt, pb, sb, 1'b1);
      idle($urandom_range(3, 0));
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
